// File: rtl/data_sync_tx_pkg.sv
// data_sync_tx_pkg: state encoding and default synchronizer depth shared by both ends of the bus crossing
package data_sync_tx_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    REQ   = 3'd2,
    REL   = 3'd3,
    GAP   = 3'd4
  } state_e;
  localparam int DEFAULT_STAGES = 2;
endpackage

// File: rtl/data_sync_tx_bit_sync.sv
// bit_sync: STAGES-deep single-bit synchronizer chain with async active-low clear
module bit_sync
  import data_sync_tx_pkg::*;
#(
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sync_q <= '0;
    else sync_q <= {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/data_sync_tx.sv
// data_sync_tx: source-side launcher holding a stable bus under a four-phase req/ack handshake
module data_sync_tx
  import data_sync_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STAGES     = DEFAULT_STAGES,
  parameter int GAP_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             ack_async,
  output logic [WIDTH-1:0] unsync_bus,
  output logic             bus_enable,
  output logic             busy
);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  state_e state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic en_q, en_d, ack_sync, accept;
  bit_sync #(.STAGES(STAGES)) u_ack_sync (
    .clk_i (CLK),
    .rst_ni(RST),
    .d_i   (ack_async),
    .q_o   (ack_sync)
  );
  // Gated by RST so ready stays low while reset is held, not just after it.
  assign data_ready = RST && state_q == IDLE && !ack_sync;
  assign accept     = data_valid && data_ready;
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    bus_d   = accept ? data_in : bus_q;
    unique case (state_q)
      IDLE:  state_d = accept ? SETUP : IDLE;
      SETUP: state_d = REQ;
      REQ:   state_d = ack_sync ? REL : REQ;
      REL: begin
        state_d = ack_sync ? REL : (GAP_CYCLES > 0 ? GAP : IDLE);
        gap_d   = GAP_INIT;
      end
      GAP: begin
        state_d = gap_q == '0 ? IDLE : GAP;
        gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Decoding enable from the next state keeps the flop output glitch-free.
    en_d = state_d == REQ;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q <= IDLE;
      gap_q   <= '0;
      bus_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      bus_q   <= bus_d;
      en_q    <= en_d;
    end
  assign unsync_bus = bus_q;
  assign bus_enable = en_q;
  assign busy       = state_q != IDLE;
endmodule
